// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: ALU opcode map,
// instruction word field positions and the sequencer state encoding.
package instr_sequencer_pkg;

    localparam int PC_W_DEF        = 4;
    localparam int EXEC_CYCLES_DEF = 3;

    // ALU opcodes understood by the controller
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADD_A = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SUB_A = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_AND_A = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_OR_A  = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;

    localparam logic [3:0] LAST_ALU_OP_DEF = OP_SHR;
    localparam logic [3:0] HALT_OP_DEF     = 4'hF;

    // Instruction word layout: [7:4] opcode, [3:0] operand
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPD_MSB = 3;
    localparam int OPD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALTED = 3'd5
    } seq_state_t;

    function automatic logic [3:0] word_opcode(input logic [7:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] word_operand(input logic [7:0] word);
        return word[OPD_MSB:OPD_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-issue bus: ROM read port on one side, opcode/op/operand
// towards the controller on the other. The sequencer is the master.
interface instr_sequencer_if #(
    parameter int PC_W = 4
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic [3:0]      opcode;
    logic            op;
    logic [3:0]      operand;

    modport master (
        output imem_en, imem_addr, opcode, op, operand,
        input  imem_data
    );

    modport slave (
        input  imem_en, imem_addr, opcode, op, operand,
        output imem_data
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetches 8-bit words from a 1-cycle synchronous ROM, issues one ALU
// instruction per slot with a single-cycle op strobe, then waits out the
// controller's execution time before fetching the next word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// FETCH   | imem_en asserted with imem_addr = pc
// WAIT    | ROM word valid; decode, bump pc, issue or halt
// ISSUE   | op strobe high for this single cycle
// EXEC    | remaining execution cycles counted down to zero
// HALTED  | HALT or illegal opcode seen; waiting for start
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int         PC_W        = PC_W_DEF,
    parameter int         EXEC_CYCLES = EXEC_CYCLES_DEF,
    parameter logic [3:0] HALT_OP     = HALT_OP_DEF,
    parameter logic [3:0] LAST_ALU_OP = LAST_ALU_OP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    instr_sequencer_if.master   bus,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted,
    output logic                illegal
);

    // ISSUE already accounts for one execution cycle, and the EXEC state
    // spends one cycle at count zero, hence the -2.
    localparam logic [3:0] EXEC_LOAD = (EXEC_CYCLES >= 2) ? 4'(EXEC_CYCLES - 2) : 4'd0;

    seq_state_t state;
    logic [3:0] exec_cnt;
    logic [3:0] word_op;
    logic [3:0] word_opd;

    assign word_op       = word_opcode(bus.imem_data);
    assign word_opd      = word_operand(bus.imem_data);
    assign bus.imem_addr = pc;

    // Sequencer FSM with all outputs registered; op and imem_en are one-cycle strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            exec_cnt    <= '0;
            bus.opcode  <= '0;
            bus.operand <= '0;
            bus.op      <= 1'b0;
            bus.imem_en <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            bus.op      <= 1'b0;
            bus.imem_en <= 1'b0;
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state       <= ST_FETCH;
                        pc          <= '0;
                        illegal     <= 1'b0;
                        halted      <= 1'b0;
                        busy        <= 1'b1;
                        bus.imem_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    pc <= pc + PC_W'(1);
                    if (word_op <= LAST_ALU_OP) begin
                        state       <= ST_ISSUE;
                        bus.op      <= 1'b1;
                        bus.opcode  <= word_op;
                        bus.operand <= word_opd;
                    end else begin
                        state  <= ST_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        if (word_op != HALT_OP) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (EXEC_CYCLES == 1) begin
                        state       <= ST_FETCH;
                        bus.imem_en <= 1'b1;
                    end else begin
                        state    <= ST_EXEC;
                        exec_cnt <= EXEC_LOAD;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        state       <= ST_FETCH;
                        bus.imem_en <= 1'b1;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
